// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode and condition encodings, NZCV flag bit
// positions, and opcode classification helpers.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
    OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
    OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
    OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF
  } opcode_e;

  typedef enum logic [3:0] {
    CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3,
    CC_MI = 4'h4, CC_PL = 4'h5, CC_VS = 4'h6, CC_VC = 4'h7,
    CC_HI = 4'h8, CC_LS = 4'h9, CC_GE = 4'hA, CC_LT = 4'hB,
    CC_GT = 4'hC, CC_LE = 4'hD, CC_AL = 4'hE, CC_NV = 4'hF
  } cond_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // TST/TEQ/CMP/CMN occupy 8..B
  function automatic logic is_compare(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

  // Arithmetic ops: SUB..RSC (2..7), CMP, CMN
  function automatic logic is_arith(input logic [3:0] op);
    return (op[3:2] == 2'b00 && op[1]) || (op[3:2] == 2'b01) ||
           (op[3:2] == 2'b10 && op[1]);
  endfunction

endpackage

// File: rtl/cond_check.sv
// Condition-code evaluation.
//   cond  : instruction condition field
//   flags : current NZCV
//   pass  : 1 when the condition holds
module cond_check
  import alu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond)
      CC_EQ: pass = z;
      CC_NE: pass = !z;
      CC_CS: pass = c;
      CC_CC: pass = !c;
      CC_MI: pass = n;
      CC_PL: pass = !n;
      CC_VS: pass = v;
      CC_VC: pass = !v;
      CC_HI: pass = c && !z;
      CC_LS: pass = !c || z;
      CC_GE: pass = (n == v);
      CC_LT: pass = (n != v);
      CC_GT: pass = !z && (n == v);
      CC_LE: pass = z || (n != v);
      CC_AL: pass = 1'b1;
      CC_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_writeback.sv
// Conditional writeback stage: evaluates the condition against the
// registered NZCV flags, updates flags, and retires the op one cycle later.
//   clk, reset          : clock, asynchronous active-high reset
//   in_valid/stall/flush: stage handshake and control
//   cond/opcode/s_bit   : instruction fields
//   alu_result/alu_flags/shifter_carry/rd : execute-stage data
//   cond_pass           : combinational condition result for current input
//   carry_out/flags     : registered C and NZCV
//   out_*               : registered retirement outputs
module cond_writeback
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic [3:0]       cond,
  input  logic [3:0]       opcode,
  input  logic             s_bit,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [3:0]       alu_flags,
  input  logic             shifter_carry,
  input  logic [3:0]       rd,
  output logic             cond_pass,
  output logic             carry_out,
  output logic [3:0]       flags,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_rd,
  output logic             out_reg_write
);

  logic [3:0]       flags_q,     flags_d;
  logic             valid_q,     valid_d;
  logic [WIDTH-1:0] result_q,    result_d;
  logic [3:0]       rd_q,        rd_d;
  logic             reg_write_q, reg_write_d;

  logic is_cmp;

  // Condition sees registered flags, so back-to-back ops chain naturally
  cond_check u_cond_check (
    .cond  (cond),
    .flags (flags_q),
    .pass  (cond_pass)
  );

  assign is_cmp = is_compare(opcode);

  // Next-state: flush beats stall beats accept
  always_comb begin
    flags_d     = flags_q;
    valid_d     = valid_q;
    result_d    = result_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;

    if (flush) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
    end else if (stall) begin
      // hold everything
    end else if (in_valid) begin
      valid_d     = 1'b1;
      result_d    = alu_result;
      rd_d        = rd;
      reg_write_d = cond_pass && !is_cmp;
      if (cond_pass && (s_bit || is_cmp)) begin
        if (is_arith(opcode)) begin
          flags_d = alu_flags;
        end else begin
          // logical ops take C from the shifter and keep V
          flags_d = {alu_flags[FLAG_N], alu_flags[FLAG_Z], shifter_carry, flags_q[FLAG_V]};
        end
      end
    end else begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q     <= 4'b0000;
      valid_q     <= 1'b0;
      result_q    <= '0;
      rd_q        <= 4'd0;
      reg_write_q <= 1'b0;
    end else begin
      flags_q     <= flags_d;
      valid_q     <= valid_d;
      result_q    <= result_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
    end
  end

  assign flags         = flags_q;
  assign carry_out     = flags_q[FLAG_C];
  assign out_valid     = valid_q;
  assign out_result    = result_q;
  assign out_rd        = rd_q;
  assign out_reg_write = reg_write_q;

endmodule

// File: tb/tb_cond_writeback.sv
// Self-checking bench for cond_writeback: directed vector table plus
// hand-written reset sequences.
module tb_cond_writeback;

  localparam int unsigned WIDTH = 32;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             stall;
  logic             flush;
  logic [3:0]       cond;
  logic [3:0]       opcode;
  logic             s_bit;
  logic [WIDTH-1:0] alu_result;
  logic [3:0]       alu_flags;
  logic             shifter_carry;
  logic [3:0]       rd;
  logic             cond_pass;
  logic             carry_out;
  logic [3:0]       flags;
  logic             out_valid;
  logic [WIDTH-1:0] out_result;
  logic [3:0]       out_rd;
  logic             out_reg_write;

  cond_writeback #(.WIDTH(WIDTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .stall         (stall),
    .flush         (flush),
    .cond          (cond),
    .opcode        (opcode),
    .s_bit         (s_bit),
    .alu_result    (alu_result),
    .alu_flags     (alu_flags),
    .shifter_carry (shifter_carry),
    .rd            (rd),
    .cond_pass     (cond_pass),
    .carry_out     (carry_out),
    .flags         (flags),
    .out_valid     (out_valid),
    .out_result    (out_result),
    .out_rd        (out_rd),
    .out_reg_write (out_reg_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v, st, fl;
    logic [3:0]  cnd, op;
    logic        s;
    logic [31:0] res;
    logic [3:0]  af;
    logic        sc;
    logic [3:0]  rd;
    logic        e_pass;
    logic [3:0]  e_flags;
    logic        e_ov;
    logic [31:0] e_res;
    logic [3:0]  e_rd;
    logic        e_wr;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  vec_t vecs[17];

  function automatic vec_t mk(input logic v, st, fl, input logic [3:0] cnd, op,
                              input logic s, input logic [31:0] res,
                              input logic [3:0] af, input logic sc, input logic [3:0] r,
                              input logic e_pass, input logic [3:0] e_flags,
                              input logic e_ov, input logic [31:0] e_res,
                              input logic [3:0] e_rd, input logic e_wr);
    vec_t t;
    t.v = v; t.st = st; t.fl = fl; t.cnd = cnd; t.op = op; t.s = s;
    t.res = res; t.af = af; t.sc = sc; t.rd = r;
    t.e_pass = e_pass; t.e_flags = e_flags; t.e_ov = e_ov;
    t.e_res = e_res; t.e_rd = e_rd; t.e_wr = e_wr;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [3:0] e_flags, input logic e_ov,
                          input logic [31:0] e_res, input logic [3:0] e_rd, input logic e_wr);
    chk({tag, " flags"}, 32'(flags), 32'(e_flags));
    chk({tag, " carry_out"}, 32'(carry_out), 32'(e_flags[1]));
    chk({tag, " out_valid"}, 32'(out_valid), 32'(e_ov));
    chk({tag, " out_result"}, out_result, e_res);
    chk({tag, " out_rd"}, 32'(out_rd), 32'(e_rd));
    chk({tag, " out_reg_write"}, 32'(out_reg_write), 32'(e_wr));
  endtask

  task automatic drive(input logic v, st, fl, input logic [3:0] cnd, op, input logic s,
                       input logic [31:0] res, input logic [3:0] af, input logic sc,
                       input logic [3:0] r);
    in_valid = v; stall = st; flush = fl; cond = cnd; opcode = op; s_bit = s;
    alu_result = res; alu_flags = af; shifter_carry = sc; rd = r;
  endtask

  initial begin
    //          v  st fl cnd   op    s  res      af     sc r       pass flags  ov res      rd    wr
    vecs[0]  = mk(1, 0, 0, 4'hE, 4'hA, 0, 32'h99, 4'b0110, 0, 4'd7,  1, 4'b0110, 1, 32'h99, 4'd7,  0); // CMP AL
    vecs[1]  = mk(1, 0, 0, 4'h0, 4'h4, 0, 32'h05, 4'b1111, 0, 4'd3,  1, 4'b0110, 1, 32'h05, 4'd3,  1); // ADD EQ
    vecs[2]  = mk(1, 0, 0, 4'h1, 4'h2, 1, 32'h09, 4'b1000, 0, 4'd4,  0, 4'b0110, 1, 32'h09, 4'd4,  0); // SUBS NE fails
    vecs[3]  = mk(1, 0, 0, 4'hE, 4'h4, 1, 32'h10, 4'b0111, 0, 4'd1,  1, 4'b0111, 1, 32'h10, 4'd1,  1); // ADDS AL
    vecs[4]  = mk(1, 0, 0, 4'hE, 4'hC, 1, 32'h20, 4'b1000, 0, 4'd2,  1, 4'b1001, 1, 32'h20, 4'd2,  1); // ORRS keeps V
    vecs[5]  = mk(0, 0, 0, 4'hF, 4'h4, 1, 32'hEE, 4'b0000, 0, 4'd15, 0, 4'b1001, 0, 32'h20, 4'd2,  0); // idle
    vecs[6]  = mk(1, 0, 0, 4'hF, 4'hD, 1, 32'h30, 4'b0100, 1, 4'd5,  0, 4'b1001, 1, 32'h30, 4'd5,  0); // NV
    vecs[7]  = mk(1, 0, 0, 4'hA, 4'h8, 0, 32'h40, 4'b0100, 1, 4'd6,  1, 4'b0111, 1, 32'h40, 4'd6,  0); // TST GE
    vecs[8]  = mk(1, 0, 0, 4'hB, 4'hB, 0, 32'h50, 4'b1010, 0, 4'd8,  1, 4'b1010, 1, 32'h50, 4'd8,  0); // CMN LT
    vecs[9]  = mk(1, 0, 0, 4'h8, 4'h1, 1, 32'h60, 4'b0100, 0, 4'd9,  1, 4'b0100, 1, 32'h60, 4'd9,  1); // EORS HI
    vecs[10] = mk(1, 0, 0, 4'h9, 4'h3, 0, 32'h70, 4'b1111, 1, 4'd10, 1, 4'b0100, 1, 32'h70, 4'd10, 1); // RSB LS
    vecs[11] = mk(1, 0, 0, 4'hC, 4'h4, 1, 32'h80, 4'b0000, 0, 4'd11, 0, 4'b0100, 1, 32'h80, 4'd11, 0); // ADDS GT fails
    vecs[12] = mk(1, 0, 0, 4'hD, 4'hE, 1, 32'h90, 4'b1000, 1, 4'd12, 1, 4'b1010, 1, 32'h90, 4'd12, 1); // BICS LE
    vecs[13] = mk(1, 1, 0, 4'h4, 4'hA, 1, 32'hA0, 4'b0001, 0, 4'd13, 1, 4'b1010, 1, 32'h90, 4'd12, 1); // stall
    vecs[14] = mk(1, 1, 0, 4'h4, 4'hA, 1, 32'hA0, 4'b0001, 0, 4'd13, 1, 4'b1010, 1, 32'h90, 4'd12, 1); // stall
    vecs[15] = mk(1, 1, 1, 4'h4, 4'hA, 1, 32'hA0, 4'b0001, 0, 4'd13, 1, 4'b1010, 0, 32'h90, 4'd12, 0); // stall+flush
    vecs[16] = mk(1, 0, 1, 4'hE, 4'hA, 1, 32'hB0, 4'b0001, 0, 4'd14, 1, 4'b1010, 0, 32'h90, 4'd12, 0); // flush

    drive(0, 0, 0, 4'hE, 4'h0, 0, 32'h0, 4'h0, 0, 4'd0);
    reset = 1'b1;
    #1;
    chk_outs("reset", 4'b0000, 0, 32'h0, 4'd0, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].v, vecs[i].st, vecs[i].fl, vecs[i].cnd, vecs[i].op, vecs[i].s,
            vecs[i].res, vecs[i].af, vecs[i].sc, vecs[i].rd);
      #1;
      chk($sformatf("v%0d cond_pass", i), 32'(cond_pass), 32'(vecs[i].e_pass));
      @(posedge clk);
      #1;
      chk_outs($sformatf("v%0d", i), vecs[i].e_flags, vecs[i].e_ov, vecs[i].e_res,
               vecs[i].e_rd, vecs[i].e_wr);
      @(negedge clk);
    end

    // Reset pulsed between edges clears everything without a clock edge
    drive(1, 0, 0, 4'hE, 4'hA, 0, 32'hC0, 4'b1110, 0, 4'd3);
    @(posedge clk);
    #1;
    chk_outs("pre-async", 4'b1110, 1, 32'hC0, 4'd3, 0);
    drive(1, 0, 0, 4'hE, 4'h4, 1, 32'hAA, 4'b0011, 0, 4'd13);
    #1;
    reset = 1'b1;
    #1;
    chk_outs("async reset", 4'b0000, 0, 32'h0, 4'd0, 0);
    #1;
    reset = 1'b0;
    // First accept is the next rising edge after release
    @(posedge clk);
    #1;
    chk_outs("post-reset accept", 4'b0011, 1, 32'hAA, 4'd13, 1);

    // Op held across a reset spanning an edge is discarded
    @(negedge clk);
    drive(1, 0, 0, 4'hE, 4'h4, 1, 32'h55, 4'b1000, 0, 4'd9);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_outs("reset over edge", 4'b0000, 0, 32'h0, 4'd0, 0);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 0, 4'hE, 4'h0, 0, 32'h0, 4'h0, 0, 4'd0);
    @(posedge clk);
    #1;
    chk_outs("idle after reset", 4'b0000, 0, 32'h0, 4'd0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cond_writeback.md
COND_WRITEBACK -- requirements
Module: cond_writeback

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width of result.
REQ-002 SHALL have ports:
  clk  in  1  sole clock, rising edge
  reset  in  1  asynchronous, active-high
  in_valid  in  1  execute-stage op present
  stall  in  1  hold stage, accept nothing
  flush  in  1  kill current and retiring op
  cond  in  4  instruction condition field
  opcode  in  4  ALU opcode, 0 AND .. F MVN
  s_bit  in  1  set-flags request
  alu_result  in  WIDTH  ALU output
  alu_flags  in  4  ALU NZCV, [3]N [2]Z [1]C [0]V
  shifter_carry  in  1  shifter carry-out for logical ops
  rd  in  4  destination register
  cond_pass  out  1  condition met for current input
  carry_out  out  1  registered C, drives ALU carry input
  flags  out  4  registered NZCV
  out_valid  out  1  op retired this cycle
  out_result  out  WIDTH  registered result
  out_rd  out  4  registered destination
  out_reg_write  out  1  register-file write enable

Function
REQ-003 cond_pass SHALL be combinational from cond and registered flags: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F never 0.
REQ-004 Accept SHALL occur when in_valid=1, stall=0, flush=0.
REQ-005 Compare ops (opcode 8..B: TST TEQ CMP CMN) SHALL never write a register and SHALL always request flag write.
REQ-006 Flags SHALL update on accept when cond_pass=1 and (s_bit=1 or compare op); otherwise flags hold.
REQ-007 Arithmetic ops (2..7, A, B) SHALL load NZCV from alu_flags.
REQ-008 Logical ops (0, 1, 8, 9, C, D, E, F) SHALL load N,Z from alu_flags, C from shifter_carry, and preserve V.
REQ-009 On accept: out_valid<=1, out_result<=alu_result, out_rd<=rd, out_reg_write<=cond_pass & !compare op; latency one cycle.
REQ-010 Condition-failed op SHALL still retire (out_valid=1, out_reg_write=0).
REQ-011 in_valid=0, stall=0, flush=0: out_valid<=0, out_reg_write<=0; out_result, out_rd hold.
REQ-012 stall=1, flush=0: all output registers and flags SHALL hold.
REQ-013 flush=1: out_valid<=0, out_reg_write<=0, flags hold; flush SHALL override stall and in_valid.
REQ-014 Back-to-back ops: the second op's cond_pass SHALL see flags written by the first, without bypass logic.
REQ-015 carry_out SHALL equal flags[1] at all times.

Reset
REQ-016 reset=1 SHALL immediately, without a clock edge, force flags=0000, out_valid=0, out_result=0, out_rd=0, out_reg_write=0.
REQ-017 An op in flight when reset asserts SHALL be discarded; first accept SHALL be the first rising edge after reset deasserts.

Structure
REQ-018 Package alu_pkg SHALL hold the opcode enum (16 codes), the condition enum (16 codes), and flag index constants N=3, Z=2, C=1, V=0, shared with the ALU.
REQ-019 Condition evaluation SHALL be a combinational sub-module cond_check (cond, flags -> pass).

Verification
REQ-020 Reset, then CMP, cond=E, alu_flags=0110 -> next cycle flags=0110, out_valid=1, out_reg_write=0, carry_out=1.
REQ-021 Flags=0110, ADD, cond=0 EQ, s_bit=0, alu_result=5, rd=3 -> cond_pass=1, out_result=5, out_rd=3, out_reg_write=1, flags stay 0110.
REQ-022 Flags=0110, SUB, cond=1 NE, s_bit=1, alu_flags=1000 -> cond_pass=0, out_valid=1, out_reg_write=0, flags stay 0110.
REQ-023 Flags=0111, ORR, cond=E, s_bit=1, alu_flags=1000, shifter_carry=0 -> flags=1001 (V preserved).
REQ-024 in_valid=1, stall=1 for 2 cycles -> outputs and flags frozen; stall=1, flush=1 -> out_valid=0, flags unchanged.
REQ-025 cond=F with any flags -> cond_pass=0; reset pulsed between clock edges -> all outputs 0 before the next edge.
